btb_assoc: RTL and testbench

Parametrised N-way set-associative Branch Target Buffer with a registered lookup, and the successor to the direct-mapped BTB used in early fetch bring-up. It predicts taken-branch targets for the fetch stage and is trained by the branch resolution unit. It adds configurable sets/ways, partial tags, per-set round-robin replacement, invalidation on not-taken, and a sequential flush engine.

---
 rtl/btb_assoc_if.sv | 33 +++
 rtl/btb_assoc.sv | 158 +++++++++++++++
 tb/tb_btb_assoc.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/btb_assoc_if.sv
// Fetch-side lookup, resolution-side training and flush control bundle for btb_assoc.
// The master drives requests/updates/flush; the slave (the BTB) returns predictions and busy.
interface btb_assoc_if #(
  parameter int unsigned PC_W = 64,
  parameter int unsigned WAYS = 4
);
  localparam int unsigned WAY_W = $clog2(WAYS);

  logic             req_valid_i;
  logic [PC_W-1:0]  req_pc_i;
  logic             pred_valid_o;
  logic             pred_hit_o;
  logic [PC_W-1:0]  pred_target_o;
  logic [WAY_W-1:0] pred_way_o;
  logic             update_valid_i;
  logic [PC_W-1:0]  update_pc_i;
  logic [PC_W-1:0]  update_target_i;
  logic             update_taken_i;
  logic             flush_i;
  logic             busy_o;

  modport master (
    output req_valid_i, req_pc_i, update_valid_i, update_pc_i, update_target_i,
           update_taken_i, flush_i,
    input  pred_valid_o, pred_hit_o, pred_target_o, pred_way_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_pc_i, update_valid_i, update_pc_i, update_target_i,
           update_taken_i, flush_i,
    output pred_valid_o, pred_hit_o, pred_target_o, pred_way_o, busy_o
  );
endinterface

// File: rtl/btb_assoc.sv
// N-way set-associative branch target buffer: registered lookup, partial tags, per-set
// round-robin replacement, invalidate-on-not-taken training and a sequential flush walk.
module btb_assoc #(
  parameter int unsigned PC_W  = 64,
  parameter int unsigned SETS  = 1024,
  parameter int unsigned WAYS  = 4,
  parameter int unsigned TAG_W = 20
) (
  input logic        clk,
  input logic        rst_n,
  btb_assoc_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);

  typedef enum logic [0:0] {StFlush, StIdle} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  // Storage has no reset; the flush walk that follows reset clears valid bits and pointers.
  logic [WAYS-1:0]  valid_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [PC_W-1:0]  tgt_q   [SETS][WAYS];
  logic [WAY_W-1:0] rr_q    [SETS];

  logic             pred_valid_q, pred_valid_d;
  logic             pred_hit_q, pred_hit_d;
  logic [PC_W-1:0]  pred_target_q, pred_target_d;
  logic [WAY_W-1:0] pred_way_q, pred_way_d;

  logic [IDX_W-1:0] req_idx, upd_idx;
  logic [TAG_W-1:0] req_tag, upd_tag;
  logic             accept, req_en, upd_en;
  logic             lk_hit, up_hit, free_found;
  logic [WAY_W-1:0] lk_way, up_way, free_way, alloc_way;

  assign req_idx = bus.req_pc_i[IDX_W+1:2];
  assign req_tag = bus.req_pc_i[IDX_W+1+TAG_W:IDX_W+2];
  assign upd_idx = bus.update_pc_i[IDX_W+1:2];
  assign upd_tag = bus.update_pc_i[IDX_W+1+TAG_W:IDX_W+2];

  // A flush request drops any lookup or update presented alongside it.
  assign accept = (state_q == StIdle) && !bus.flush_i;
  assign req_en = accept && bus.req_valid_i;
  assign upd_en = accept && bus.update_valid_i;

  logic unused_upd_pc;
  assign unused_upd_pc = ^bus.update_pc_i;

  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!lk_hit && valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    up_hit     = 1'b0;
    up_way     = '0;
    free_found = 1'b0;
    free_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!up_hit && valid_q[upd_idx][w] && (tag_q[upd_idx][w] == upd_tag)) begin
        up_hit = 1'b1;
        up_way = WAY_W'(w);
      end
      if (!free_found && !valid_q[upd_idx][w]) begin
        free_found = 1'b1;
        free_way   = WAY_W'(w);
      end
    end
    alloc_way = free_found ? free_way : rr_q[upd_idx];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StFlush: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(SETS - 1)) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (bus.flush_i) begin
          state_d = StFlush;
          cnt_d   = '0;
        end
      end
      default: state_d = StFlush;
    endcase
  end

  // Lookup reads pre-update contents, giving read-before-write against same-cycle training.
  always_comb begin
    pred_valid_d  = req_en;
    pred_hit_d    = pred_hit_q;
    pred_target_d = pred_target_q;
    pred_way_d    = pred_way_q;
    if (req_en) begin
      pred_hit_d    = lk_hit;
      pred_target_d = lk_hit ? tgt_q[req_idx][lk_way] : bus.req_pc_i + PC_W'(4);
      pred_way_d    = lk_way;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StFlush;
      cnt_q         <= '0;
      pred_valid_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_target_q <= '0;
      pred_way_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pred_valid_q  <= pred_valid_d;
      pred_hit_q    <= pred_hit_d;
      pred_target_q <= pred_target_d;
      pred_way_q    <= pred_way_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StFlush) begin
      valid_q[cnt_q] <= '0;
      rr_q[cnt_q]    <= '0;
    end else if (upd_en) begin
      if (up_hit) begin
        if (bus.update_taken_i) begin
          tgt_q[upd_idx][up_way] <= bus.update_target_i;
        end else begin
          valid_q[upd_idx][up_way] <= 1'b0;
        end
      end else if (bus.update_taken_i) begin
        valid_q[upd_idx][alloc_way] <= 1'b1;
        tag_q[upd_idx][alloc_way]   <= upd_tag;
        tgt_q[upd_idx][alloc_way]   <= bus.update_target_i;
        if (!free_found) begin
          rr_q[upd_idx] <= rr_q[upd_idx] + WAY_W'(1);
        end
      end
    end
  end

  assign bus.pred_valid_o  = pred_valid_q;
  assign bus.pred_hit_o    = pred_hit_q;
  assign bus.pred_target_o = pred_target_q;
  assign bus.pred_way_o    = pred_way_q;
  assign bus.busy_o        = (state_q == StFlush);
endmodule

// File: tb/tb_btb_assoc.sv
// Scenario bench for btb_assoc with default parameters; expected predictions are queued
// when a lookup is issued and popped when the registered response appears.
module tb_btb_assoc;
  typedef struct packed {
    logic        hit;
    logic [63:0] tgt;
    logic [1:0]  way;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];

  btb_assoc_if #(.PC_W(64), .WAYS(4)) bus ();

  btb_assoc #(
    .PC_W (64),
    .SETS (1024),
    .WAYS (4),
    .TAG_W(20)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic cyc(input logic rv, input logic [63:0] rpc, input logic uv,
                     input logic [63:0] upc, input logic [63:0] utgt, input logic ut,
                     input logic fl);
    bus.req_valid_i     = rv;
    bus.req_pc_i        = rpc;
    bus.update_valid_i  = uv;
    bus.update_pc_i     = upc;
    bus.update_target_i = utgt;
    bus.update_taken_i  = ut;
    bus.flush_i         = fl;
    @(posedge clk);
    #1;
    bus.req_valid_i    = 1'b0;
    bus.update_valid_i = 1'b0;
    bus.flush_i        = 1'b0;
  endtask

  task automatic test_reset;
    exp_t        e, got;
    int          n, bad;
    logic [63:0] pcs[2];
    pcs = '{64'h1000, 64'hFFFF_FFFF_FFFF_FFFC};
    n_checks++;
    if ({bus.busy_o, bus.pred_valid_o, bus.pred_hit_o, bus.pred_target_o, bus.pred_way_o}
        !== {1'b1, 1'b0, 1'b0, 64'h0, 2'd0})
      $display("FAIL reset_state: busy=%b valid=%b hit=%b tgt=%h way=%0d, want 1 0 0 0 0",
               bus.busy_o, bus.pred_valid_o, bus.pred_hit_o, bus.pred_target_o,
               bus.pred_way_o);
    else n_pass++;
    rst_n = 1'b1;
    n = 0;
    bad = 0;
    while (bus.busy_o && n < 2000) begin
      cyc(1'b1, 64'h1000, 1'b1, 64'h1000, 64'h5555, 1'b1, 1'b0);
      n++;
      if (bus.pred_valid_o !== 1'b0) bad++;
    end
    n_checks++;
    if (n != 1024) $display("FAIL reset_busy_len: busy cycles %0d, want 1024", n);
    else n_pass++;
    n_checks++;
    if (bad != 0) $display("FAIL reset_busy_req: %0d valid predictions while busy, want 0", bad);
    else n_pass++;
    sb.push_back({1'b0, 64'h1004, 2'd0});
    sb.push_back({1'b0, 64'h0, 2'd0});
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, pcs[i], 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
      got = {bus.pred_hit_o, bus.pred_target_o, bus.pred_way_o};
      e = sb.pop_front();
      n_checks++;
      if (bus.pred_valid_o !== 1'b1 || got !== e)
        $display("FAIL reset_miss[%0d]: valid=%b hit=%b tgt=%h way=%0d, want 1 %b %h %0d", i,
                 bus.pred_valid_o, got.hit, got.tgt, got.way, e.hit, e.tgt, e.way);
      else n_pass++;
    end
  endtask

  task automatic test_hit_overwrite;
    exp_t        e, got;
    logic [63:0] tg[2];
    tg = '{64'h8000, 64'h9000};
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 64'h0, 1'b1, 64'h1000, tg[i], 1'b1, 1'b0);
      sb.push_back({1'b1, tg[i], 2'd0});
      cyc(1'b1, 64'h1000, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
      got = {bus.pred_hit_o, bus.pred_target_o, bus.pred_way_o};
      e = sb.pop_front();
      n_checks++;
      if (bus.pred_valid_o !== 1'b1 || got !== e)
        $display("FAIL hit_overwrite[%0d]: valid=%b hit=%b tgt=%h way=%0d, want 1 %b %h %0d", i,
                 bus.pred_valid_o, got.hit, got.tgt, got.way, e.hit, e.tgt, e.way);
      else n_pass++;
    end
  endtask

  task automatic test_evict;
    exp_t        e, got;
    logic [63:0] lk_pc[6];
    exp_t        lk_exp[6];
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 64'h0, 1'b1, 64'((i + 1) * 'h1000), 64'('hA000 + i * 'h1000), 1'b1, 1'b0);
    lk_pc = '{64'h1000, 64'h5000, 64'h2000, 64'h3000, 64'h4000, 64'h1_0000_5000};
    lk_exp[0] = {1'b0, 64'h1004, 2'd0};
    lk_exp[1] = {1'b1, 64'hE000, 2'd0};
    lk_exp[2] = {1'b1, 64'hB000, 2'd1};
    lk_exp[3] = {1'b1, 64'hC000, 2'd2};
    lk_exp[4] = {1'b1, 64'hD000, 2'd3};
    lk_exp[5] = {1'b1, 64'hE000, 2'd0};
    for (int i = 0; i < 6; i++) begin
      sb.push_back(lk_exp[i]);
      cyc(1'b1, lk_pc[i], 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
      got = {bus.pred_hit_o, bus.pred_target_o, bus.pred_way_o};
      e = sb.pop_front();
      n_checks++;
      if (bus.pred_valid_o !== 1'b1 || got !== e)
        $display("FAIL evict[%0d] pc=%h: valid=%b hit=%b tgt=%h way=%0d, want 1 %b %h %0d", i,
                 lk_pc[i], bus.pred_valid_o, got.hit, got.tgt, got.way, e.hit, e.tgt, e.way);
      else n_pass++;
    end
  endtask

  task automatic test_invalidate;
    exp_t e, got;
    cyc(1'b0, 64'h0, 1'b1, 64'h3000, 64'h0, 1'b0, 1'b0);
    sb.push_back({1'b0, 64'h3004, 2'd0});
    cyc(1'b1, 64'h3000, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    got = {bus.pred_hit_o, bus.pred_target_o, bus.pred_way_o};
    e = sb.pop_front();
    n_checks++;
    if (bus.pred_valid_o !== 1'b1 || got !== e)
      $display("FAIL invalidate_miss: valid=%b hit=%b tgt=%h way=%0d, want 1 %b %h %0d",
               bus.pred_valid_o, got.hit, got.tgt, got.way, e.hit, e.tgt, e.way);
    else n_pass++;
    cyc(1'b0, 64'h0, 1'b1, 64'h6000, 64'hF000, 1'b1, 1'b0);
    sb.push_back({1'b1, 64'hF000, 2'd2});
    cyc(1'b1, 64'h6000, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    got = {bus.pred_hit_o, bus.pred_target_o, bus.pred_way_o};
    e = sb.pop_front();
    n_checks++;
    if (bus.pred_valid_o !== 1'b1 || got !== e)
      $display("FAIL refill_free_way: valid=%b hit=%b tgt=%h way=%0d, want 1 %b %h %0d",
               bus.pred_valid_o, got.hit, got.tgt, got.way, e.hit, e.tgt, e.way);
    else n_pass++;
  endtask

  // Set 0 is full with rr = 1 here, so 0x7000 replaces way 1 (0x2000).
  task automatic test_back_to_back;
    exp_t        e, got;
    logic [63:0] pcs[3];
    pcs = '{64'h7000, 64'h7000, 64'h2000};
    sb.push_back({1'b0, 64'h7004, 2'd0});
    sb.push_back({1'b1, 64'h7700, 2'd1});
    sb.push_back({1'b0, 64'h2004, 2'd0});
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, pcs[i], (i == 0), 64'h7000, 64'h7700, 1'b1, 1'b0);
      got = {bus.pred_hit_o, bus.pred_target_o, bus.pred_way_o};
      e = sb.pop_front();
      n_checks++;
      if (bus.pred_valid_o !== 1'b1 || got !== e)
        $display("FAIL same_cycle[%0d]: valid=%b hit=%b tgt=%h way=%0d, want 1 %b %h %0d", i,
                 bus.pred_valid_o, got.hit, got.tgt, got.way, e.hit, e.tgt, e.way);
      else n_pass++;
    end
  endtask

  task automatic test_flush;
    exp_t        e, got;
    int          n, bad;
    logic [63:0] pcs[6];
    cyc(1'b1, 64'h5000, 1'b1, 64'h8000, 64'h1234, 1'b1, 1'b1);
    n_checks++;
    if (bus.busy_o !== 1'b1 || bus.pred_valid_o !== 1'b0)
      $display("FAIL flush_start: busy=%b valid=%b, want busy=1 valid=0", bus.busy_o,
               bus.pred_valid_o);
    else n_pass++;
    n = 0;
    bad = 0;
    while (bus.busy_o && n < 2000) begin
      cyc(1'b1, 64'h4000, (n == 10), 64'h9000, 64'h4321, 1'b1, (n == 20));
      n++;
      if (bus.pred_valid_o !== 1'b0) bad++;
    end
    n_checks++;
    if (n != 1024) $display("FAIL flush_busy_len: busy cycles %0d, want 1024", n);
    else n_pass++;
    n_checks++;
    if (bad != 0) $display("FAIL flush_busy_req: %0d valid predictions while busy, want 0", bad);
    else n_pass++;
    pcs = '{64'h8000, 64'h9000, 64'h5000, 64'h4000, 64'h7000, 64'h6000};
    for (int i = 0; i < 6; i++) begin
      sb.push_back({1'b0, pcs[i] + 64'h4, 2'd0});
      cyc(1'b1, pcs[i], 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
      got = {bus.pred_hit_o, bus.pred_target_o, bus.pred_way_o};
      e = sb.pop_front();
      n_checks++;
      if (bus.pred_valid_o !== 1'b1 || got !== e)
        $display("FAIL post_flush[%0d] pc=%h: valid=%b hit=%b tgt=%h way=%0d, want 1 %b %h %0d",
                 i, pcs[i], bus.pred_valid_o, got.hit, got.tgt, got.way, e.hit, e.tgt, e.way);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midflush;
    int n;
    cyc(1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1);
    repeat (300) cyc(1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.busy_o, bus.pred_valid_o, bus.pred_hit_o, bus.pred_target_o, bus.pred_way_o}
        !== {1'b1, 1'b0, 1'b0, 64'h0, 2'd0})
      $display("FAIL midflush_reset_state: busy=%b valid=%b hit=%b tgt=%h way=%0d, want 1 0 0 0 0",
               bus.busy_o, bus.pred_valid_o, bus.pred_hit_o, bus.pred_target_o,
               bus.pred_way_o);
    else n_pass++;
    rst_n = 1'b1;
    n = 0;
    while (bus.busy_o && n < 2000) begin
      cyc(1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
      n++;
    end
    n_checks++;
    if (n != 1024) $display("FAIL midflush_restart_len: busy cycles %0d, want 1024", n);
    else n_pass++;
  endtask

  initial begin
    bus.req_valid_i     = 1'b0;
    bus.req_pc_i        = '0;
    bus.update_valid_i  = 1'b0;
    bus.update_pc_i     = '0;
    bus.update_target_i = '0;
    bus.update_taken_i  = 1'b0;
    bus.flush_i         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_hit_overwrite();
    test_evict();
    test_invalidate();
    test_back_to_back();
    test_flush();
    test_reset_midflush();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
